reg_access_arb: RTL and testbench
=================================

Name: reg_access_arb

Overview:
Arbiter and sequencer for the single register-block port shared by the AXI-Lite read-channel and write-channel blocks. It accepts one level request from each channel and grants the port round-robin. It drives address, data, strobes and enables to the register block, and waits for a ready signal. A timeout counter forces a slave error if the register block stalls, so the AXI side can never hang.

Parameters:
ADDR_W, 8, register address width
DATA_W, 32, register data width (multiple of 8)
TIMEOUT, 16, ACCESS cycles with iPREADY low before forced error; 0 disables timeout
WR_FIRST, 1, 1 = write wins the first simultaneous request after reset; 0 = read wins

Ports:
iCLK  in  1  clock, rising edge
iRST  in  1  reset, asynchronous, active-high
iRD_REQ  in  1  read request, level, held until oRD_ACK
iRD_ADDR  in  ADDR_W  read address, stable while iRD_REQ
oRD_ACK  out  1  one-cycle read completion pulse
oRD_DATA  out  DATA_W  read data, valid with oRD_ACK
oRD_ERR  out  1  read error, valid with oRD_ACK
iWR_REQ  in  1  write request, level, held until oWR_ACK
iWR_ADDR  in  ADDR_W  write address
iWR_DATA  in  DATA_W  write data
iWR_STRB  in  DATA_W/8  byte strobes
oWR_ACK  out  1  one-cycle write completion pulse
oWR_ERR  out  1  write error, valid with oWR_ACK
oPADR  out  ADDR_W  register-block address
oPWDAT  out  DATA_W  register-block write data
oPWSTRB  out  DATA_W/8  register-block strobes
oPREN  out  1  read enable, held through access
oPWEN  out  1  write enable, held through access
iPRDAT  in  DATA_W  register-block read data
iPREADY  in  1  access complete this cycle
iPERR  in  1  access error, sampled with iPREADY
oBUSY  out  1  high in ACCESS and DONE states

Behaviour:
- Reset: iRST high at any time forces the FSM to IDLE and clears the counter.
  - All outputs are 0.
  - The last-grant flag is set so that WR_FIRST decides the first tie.
  - An in-flight access is abandoned, with no ack.
- FSM IDLE:
  - Requests are sampled only in IDLE.
  - Only one request high: grant it.
  - Both high: grant the requester not granted last.
  - Register the grant, address, data and strobes, then go to ACCESS.
- FSM ACCESS:
  - oPADR/oPWDAT/oPWSTRB are registered and held constant.
  - Exactly one of oPREN/oPWEN is high.
  - oPWDAT/oPWSTRB are 0 for reads.
- ACCESS exit on iPREADY=1:
  - Capture iPRDAT (read only) and iPERR, then go to DONE.
  - Enables drop on the following edge.
- ACCESS exit on timeout:
  - The counter increments every ACCESS cycle with iPREADY=0.
  - When it equals TIMEOUT, go to DONE with err=1 and read data 0.
  - An iPREADY arriving on that same cycle wins: the normal response is used.
- FSM DONE:
  - Pulse the granted channel's ack for exactly one cycle, with data/err.
  - Update the last-grant flag, clear the counter, return to IDLE.
- Latency: a request seen in IDLE at edge N gives ACCESS from N+1.
  - With iPREADY=1 in the first ACCESS cycle, ack is high in cycle N+2.
  - Each iPREADY wait cycle adds one.
  - Minimum spacing between back-to-back grants is 3 cycles (IDLE, ACCESS, DONE).
- Requester rule: drop the request in the cycle after its ack.
  - The arbiter returns to IDLE after DONE, so a request still high there is taken as a new transaction.
- Request dropped mid-ACCESS: the access completes and ack still pulses; this is not checked.
- iWR_STRB all zero: the access is still performed and acked with err=0.
- oRD_DATA/oRD_ERR/oWR_ERR are 0 outside their ack cycle.
- iPERR is ignored while iPREADY=0.
- TIMEOUT=0: wait indefinitely.
- Counter width is clog2(TIMEOUT+1), minimum 1; it never wraps.

Decomposition:
- Package reg_arb_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - grant enum {GNT_RD, GNT_WR};
  - localparams for reset values.
- One sub-module, reg_arb_tmo: timeout counter with clear, enable and parameterised limit, outputting an expire pulse.

Test Plan:
- Single read: iRD_REQ with addr 0x10; iPREADY=1 and iPRDAT=0xDEADBEEF in the first ACCESS cycle -> oPREN high 1 cycle, oPADR=0x10, oRD_ACK 2 cycles after the request with oRD_DATA=0xDEADBEEF, oRD_ERR=0.
- Simultaneous after reset, WR_FIRST=1: write 0xCAFEF00D to 0x04 with strb 0xF, plus read 0x08 -> write acked first, then read granted; the second ack arrives 3 cycles after the first.
- Fairness: both requests re-raised after every ack for 6 transactions -> grants strictly alternate W,R,W,R,W,R.
- Wait states and error: read 0x0C with iPREADY low for 3 cycles, then high with iPERR=1 -> oPREN high 4 cycles, oRD_ACK with oRD_ERR=1.
- Timeout: TIMEOUT=4, write with iPREADY held 0 -> exactly 4 ACCESS cycles, then oWR_ACK with oWR_ERR=1. Repeat with iPREADY rising on the 4th stalled cycle -> normal ack, err=0.
- Reset mid-access: assert iRST during ACCESS of a read -> all outputs 0 immediately, no ack. After release with both requests high, the write is granted first.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and reset values for the register-port arbiter.
// The last-grant reset value is derived from the tie-break parameter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        GNT_RD,
        GNT_WR
    } gnt_t;

    localparam state_t STATE_RST = IDLE;
    localparam gnt_t   GNT_RST   = GNT_RD;
    localparam logic   OUT_RST   = 1'b0;

    // Pretend the opposite side went last so the preferred side wins the first tie
    function automatic gnt_t last_rst(input bit wr_first);
        return wr_first ? GNT_RD : GNT_WR;
    endfunction

endpackage

// File: rtl/reg_arb_tmo.sv
// Stall counter for the register access; pulses expire on the cycle
// whose stall would make the count reach TIMEOUT. TIMEOUT=0 never expires.
module reg_arb_tmo #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (TIMEOUT > 0) && en && (cnt == LAST);

endmodule

// File: rtl/reg_access_arb.sv
// Round-robin sequencer for the register-block port shared by the
// AXI-Lite read and write channels, with a stall timeout.
module reg_access_arb
    import reg_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 16,
    parameter bit WR_FIRST = 1'b1
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iRD_REQ,
    input  logic [ADDR_W-1:0]   iRD_ADDR,
    output logic                oRD_ACK,
    output logic [DATA_W-1:0]   oRD_DATA,
    output logic                oRD_ERR,
    input  logic                iWR_REQ,
    input  logic [ADDR_W-1:0]   iWR_ADDR,
    input  logic [DATA_W-1:0]   iWR_DATA,
    input  logic [DATA_W/8-1:0] iWR_STRB,
    output logic                oWR_ACK,
    output logic                oWR_ERR,
    output logic [ADDR_W-1:0]   oPADR,
    output logic [DATA_W-1:0]   oPWDAT,
    output logic [DATA_W/8-1:0] oPWSTRB,
    output logic                oPREN,
    output logic                oPWEN,
    input  logic [DATA_W-1:0]   iPRDAT,
    input  logic                iPREADY,
    input  logic                iPERR,
    output logic                oBUSY
);
    localparam int SW = DATA_W / 8;

    state_t state, state_d;
    gnt_t   gnt, gnt_d;
    gnt_t   last, last_d;

    logic [ADDR_W-1:0] padr_d;
    logic [DATA_W-1:0] pwdat_d;
    logic [SW-1:0]     pwstrb_d;
    logic              pren_d;
    logic              pwen_d;
    logic              rd_ack_d;
    logic [DATA_W-1:0] rd_data_d;
    logic              rd_err_d;
    logic              wr_ack_d;
    logic              wr_err_d;
    logic              take_wr;
    logic              rsp_err;
    logic              tmo_clr;
    logic              tmo_en;
    logic              expire;

    reg_arb_tmo #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk   (iCLK),
        .rst   (iRST),
        .clr   (tmo_clr),
        .en    (tmo_en),
        .expire(expire)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= STATE_RST;
            gnt      <= GNT_RST;
            last     <= last_rst(WR_FIRST);
            oPADR    <= '0;
            oPWDAT   <= '0;
            oPWSTRB  <= '0;
            oPREN    <= OUT_RST;
            oPWEN    <= OUT_RST;
            oRD_ACK  <= OUT_RST;
            oRD_DATA <= '0;
            oRD_ERR  <= OUT_RST;
            oWR_ACK  <= OUT_RST;
            oWR_ERR  <= OUT_RST;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            last     <= last_d;
            oPADR    <= padr_d;
            oPWDAT   <= pwdat_d;
            oPWSTRB  <= pwstrb_d;
            oPREN    <= pren_d;
            oPWEN    <= pwen_d;
            oRD_ACK  <= rd_ack_d;
            oRD_DATA <= rd_data_d;
            oRD_ERR  <= rd_err_d;
            oWR_ACK  <= wr_ack_d;
            oWR_ERR  <= wr_err_d;
        end
    end

    always_comb begin
        state_d   = state;
        gnt_d     = gnt;
        last_d    = last;
        padr_d    = oPADR;
        pwdat_d   = oPWDAT;
        pwstrb_d  = oPWSTRB;
        pren_d    = oPREN;
        pwen_d    = oPWEN;
        rd_ack_d  = 1'b0;
        rd_data_d = '0;
        rd_err_d  = 1'b0;
        wr_ack_d  = 1'b0;
        wr_err_d  = 1'b0;
        take_wr   = 1'b0;
        rsp_err   = 1'b0;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        unique case (state)
            IDLE: begin
                tmo_clr = 1'b1;
                if (iRD_REQ || iWR_REQ) begin
                    take_wr  = iWR_REQ && (!iRD_REQ || last == GNT_RD);
                    gnt_d    = take_wr ? GNT_WR : GNT_RD;
                    padr_d   = take_wr ? iWR_ADDR : iRD_ADDR;
                    pwdat_d  = take_wr ? iWR_DATA : '0;
                    pwstrb_d = take_wr ? iWR_STRB : '0;
                    pren_d   = !take_wr;
                    pwen_d   = take_wr;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                tmo_en = !iPREADY;
                // A ready arriving on the expiring cycle still gives the real response
                if (iPREADY || expire) begin
                    rsp_err   = iPREADY ? iPERR : 1'b1;
                    rd_ack_d  = (gnt == GNT_RD);
                    rd_err_d  = (gnt == GNT_RD) && rsp_err;
                    rd_data_d = (gnt == GNT_RD && iPREADY) ? iPRDAT : '0;
                    wr_ack_d  = (gnt == GNT_WR);
                    wr_err_d  = (gnt == GNT_WR) && rsp_err;
                    padr_d    = '0;
                    pwdat_d   = '0;
                    pwstrb_d  = '0;
                    pren_d    = 1'b0;
                    pwen_d    = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                tmo_clr = 1'b1;
                last_d  = gnt;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign oBUSY = (state != IDLE);

endmodule

// File: tb/tb_reg_access_arb.sv
// Randomised and directed bench for reg_access_arb with a
// transaction-level model of arbitration, latency and timeout.
module tb_reg_access_arb;
    localparam int TMO = 4;

    logic        iCLK, iRST;
    logic        iRD_REQ, iWR_REQ;
    logic [7:0]  iRD_ADDR, iWR_ADDR;
    logic [31:0] iWR_DATA, iPRDAT;
    logic [3:0]  iWR_STRB;
    logic        iPREADY, iPERR;
    logic        oRD_ACK, oRD_ERR, oWR_ACK, oWR_ERR;
    logic [31:0] oRD_DATA, oPWDAT;
    logic [7:0]  oPADR;
    logic [3:0]  oPWSTRB;
    logic        oPREN, oPWEN, oBUSY;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit m_last_wr = 0;

    logic [82:0] all_out;
    assign all_out = {oRD_ACK, oRD_DATA, oRD_ERR, oWR_ACK, oWR_ERR, oPADR,
                      oPWDAT, oPWSTRB, oPREN, oPWEN, oBUSY};

    typedef struct {
        logic        wr;
        logic [7:0]  adr;
        logic [31:0] wdat;
        logic [3:0]  strb;
        int          en_at;
        int          en_cnt;
        int          ack_at;
        logic [31:0] rdat;
        logic        err;
        bit          clean;
        bit          done;
    } obs_t;

    reg_access_arb #(
        .ADDR_W(8), .DATA_W(32), .TIMEOUT(TMO), .WR_FIRST(1'b1)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iRD_REQ(iRD_REQ), .iRD_ADDR(iRD_ADDR),
        .oRD_ACK(oRD_ACK), .oRD_DATA(oRD_DATA), .oRD_ERR(oRD_ERR),
        .iWR_REQ(iWR_REQ), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA),
        .iWR_STRB(iWR_STRB), .oWR_ACK(oWR_ACK), .oWR_ERR(oWR_ERR),
        .oPADR(oPADR), .oPWDAT(oPWDAT), .oPWSTRB(oPWSTRB),
        .oPREN(oPREN), .oPWEN(oPWEN), .iPRDAT(iPRDAT),
        .iPREADY(iPREADY), .iPERR(iPERR), .oBUSY(oBUSY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Model: enable cycles and response for a given stall length
    function automatic int exp_en(input int stall);
        return (stall >= TMO) ? TMO : stall + 1;
    endfunction

    function automatic logic [77:0] exp_vec(input bit wr, input int stall,
                                            input logic perr, input logic [31:0] prdat);
        bit to;
        to = (stall >= TMO);
        return {wr, wr ? iWR_ADDR : iRD_ADDR, wr ? iWR_DATA : 32'h0,
                wr ? iWR_STRB : 4'h0, (!wr && !to) ? prdat : 32'h0,
                to ? 1'b1 : perr};
    endfunction

    // Register-block responder and observer for one access, ends at the ack cycle
    task automatic serve(input int stall, input logic perr, input logic [31:0] prdat,
                         output obs_t o);
        o = '{wr: 0, adr: 0, wdat: 0, strb: 0, en_at: -1, en_cnt: 0, ack_at: -1,
              rdat: 0, err: 0, clean: 1, done: 0};
        for (int i = 0; i < 60 && !o.done; i++) begin
            @(negedge iCLK);
            if (oRD_ACK || oWR_ACK) begin
                o.done   = 1;
                o.ack_at = cyc;
                o.rdat   = oRD_DATA;
                o.err    = oWR_ACK ? oWR_ERR : oRD_ERR;
                if ((oRD_ACK && oWR_ACK) || oWR_ACK != o.wr) o.clean = 0;
                if (oPREN || oPWEN || !oBUSY) o.clean = 0;
                if (oWR_ACK && oRD_ERR) o.clean = 0;
                if (oRD_ACK && oWR_ERR) o.clean = 0;
                if (oWR_ACK) iWR_REQ = 0;
                else iRD_REQ = 0;
                iPREADY = 0;
                iPERR = 0;
            end else if (oPREN || oPWEN) begin
                if ((oPREN && oPWEN) || !oBUSY) o.clean = 0;
                if (oRD_DATA != 0 || oRD_ERR || oWR_ERR) o.clean = 0;
                if (o.en_cnt == 0) begin
                    o.en_at = cyc;
                    o.adr   = oPADR;
                    o.wdat  = oPWDAT;
                    o.strb  = oPWSTRB;
                    o.wr    = oPWEN;
                end else if (oPADR != o.adr || oPWDAT != o.wdat ||
                             oPWSTRB != o.strb || oPWEN != o.wr) begin
                    o.clean = 0;
                end
                o.en_cnt++;
                iPREADY = (o.en_cnt == stall + 1);
                iPRDAT  = iPREADY ? prdat : $urandom;
                iPERR   = iPREADY ? perr : 1'($urandom);
            end else begin
                if (oBUSY || oRD_DATA != 0 || oRD_ERR || oWR_ERR) o.clean = 0;
                iPREADY = 0;
                iPERR = 0;
            end
        end
        iPREADY = 0;
        iPERR = 0;
    endtask

    task automatic apply_reset();
        iRST = 1;
        iRD_REQ = 0;
        iWR_REQ = 0;
        iPREADY = 0;
        iPERR = 0;
        repeat (2) @(negedge iCLK);
        iRST = 0;
        m_last_wr = 0;
    endtask

    task automatic test_reset();
        iRST = 1;
        iRD_REQ = 0; iWR_REQ = 0; iPREADY = 0; iPERR = 0; iPRDAT = 0;
        iRD_ADDR = 0; iWR_ADDR = 0; iWR_DATA = 0; iWR_STRB = 0;
        @(negedge iCLK);
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        iRST = 0;
        m_last_wr = 0;
        @(negedge iCLK);
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL idle_outputs: got %h want 0", all_out);
        end
    endtask

    task automatic test_single_read();
        obs_t o;
        int c;
        @(negedge iCLK);
        iRD_ADDR = 8'h10;
        iRD_REQ = 1;
        c = cyc;
        serve(0, 1'b0, 32'hDEADBEEF, o);
        m_last_wr = 0;
        checks++;
        if ({o.wr, o.adr, o.wdat, o.strb} !== {1'b0, 8'h10, 32'h0, 4'h0}) begin
            failures++;
            $display("FAIL single_read_port: got wr=%0b adr=%h wdat=%h strb=%h want 0/10/0/0",
                     o.wr, o.adr, o.wdat, o.strb);
        end
        checks++;
        if (o.en_cnt != 1 || o.en_at != c + 1) begin
            failures++;
            $display("FAIL single_read_pren: got %0d cycles at %0d want 1 at %0d",
                     o.en_cnt, o.en_at, c + 1);
        end
        checks++;
        if (o.ack_at != c + 2) begin
            failures++;
            $display("FAIL single_read_latency: got %0d want %0d", o.ack_at, c + 2);
        end
        checks++;
        if (o.rdat !== 32'hDEADBEEF || o.err !== 1'b0 || !o.clean) begin
            failures++;
            $display("FAIL single_read_rsp: got %h err=%0b clean=%0b want deadbeef err=0 clean=1",
                     o.rdat, o.err, o.clean);
        end
    endtask

    task automatic test_simultaneous();
        obs_t o1, o2;
        apply_reset();
        @(negedge iCLK);
        iWR_ADDR = 8'h04; iWR_DATA = 32'hCAFEF00D; iWR_STRB = 4'hF;
        iRD_ADDR = 8'h08;
        iWR_REQ = 1; iRD_REQ = 1;
        serve(0, 1'b0, 32'h0, o1);
        serve(0, 1'b0, 32'h12345678, o2);
        m_last_wr = 0;
        checks++;
        if ({o1.wr, o1.adr, o1.wdat, o1.strb, o1.err} !== {1'b1, 8'h04, 32'hCAFEF00D, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL simul_first: got wr=%0b adr=%h wdat=%h strb=%h err=%0b want write 04 cafef00d f 0",
                     o1.wr, o1.adr, o1.wdat, o1.strb, o1.err);
        end
        checks++;
        if ({o2.wr, o2.adr, o2.rdat} !== {1'b0, 8'h08, 32'h12345678}) begin
            failures++;
            $display("FAIL simul_second: got wr=%0b adr=%h rdat=%h want read 08 12345678",
                     o2.wr, o2.adr, o2.rdat);
        end
        checks++;
        if (o2.ack_at - o1.ack_at != 3 || !o1.done || !o2.done) begin
            failures++;
            $display("FAIL simul_spacing: got %0d want 3", o2.ack_at - o1.ack_at);
        end
    endtask

    task automatic test_fairness();
        obs_t o;
        bit e;
        int prev;
        @(negedge iCLK);
        iRD_ADDR = 8'h21; iWR_ADDR = 8'h22; iWR_DATA = 32'h55AA55AA; iWR_STRB = 4'h3;
        iRD_REQ = 1; iWR_REQ = 1;
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            e = !m_last_wr;
            serve(0, 1'b0, 32'h0, o);
            m_last_wr = e;
            iRD_REQ = (i < 5);
            iWR_REQ = (i < 5);
            checks++;
            if (o.wr !== e || !o.done) begin
                failures++;
                $display("FAIL fair_grant_%0d: got wr=%0b want wr=%0b", i, o.wr, e);
            end
            if (prev >= 0) begin
                checks++;
                if (o.ack_at - prev != 3) begin
                    failures++;
                    $display("FAIL fair_spacing_%0d: got %0d want 3", i, o.ack_at - prev);
                end
            end
            prev = o.ack_at;
        end
    endtask

    task automatic test_wait_err();
        obs_t o;
        @(negedge iCLK);
        iRD_ADDR = 8'h0C;
        iRD_REQ = 1;
        serve(3, 1'b1, 32'hA5A5_0001, o);
        m_last_wr = 0;
        checks++;
        if (o.en_cnt != 4 || o.ack_at != o.en_at + 4) begin
            failures++;
            $display("FAIL wait_pren_cycles: got %0d want 4", o.en_cnt);
        end
        checks++;
        if (o.err !== 1'b1 || o.rdat !== 32'hA5A5_0001 || o.adr !== 8'h0C || !o.clean) begin
            failures++;
            $display("FAIL wait_err_rsp: got err=%0b rdat=%h adr=%h want 1 a5a50001 0c",
                     o.err, o.rdat, o.adr);
        end
    endtask

    task automatic test_zero_strb();
        obs_t o;
        @(negedge iCLK);
        iWR_ADDR = 8'h40; iWR_DATA = 32'h0BAD_F00D; iWR_STRB = 4'h0;
        iWR_REQ = 1;
        serve(1, 1'b0, 32'h0, o);
        m_last_wr = 1;
        checks++;
        if ({o.wr, o.strb, o.err, o.done} !== {1'b1, 4'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL zero_strb: got wr=%0b strb=%h err=%0b done=%0b want 1 0 0 1",
                     o.wr, o.strb, o.err, o.done);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        @(negedge iCLK);
        iWR_ADDR = 8'h30; iWR_DATA = 32'h1; iWR_STRB = 4'h1;
        iWR_REQ = 1;
        serve(50, 1'b0, 32'h0, o);
        checks++;
        if (o.en_cnt != TMO || o.err !== 1'b1 || o.wr !== 1'b1 || !o.clean) begin
            failures++;
            $display("FAIL timeout_write: got cycles=%0d err=%0b want %0d err=1",
                     o.en_cnt, o.err, TMO);
        end
        @(negedge iCLK);
        iWR_REQ = 1;
        serve(TMO - 1, 1'b0, 32'h0, o);
        checks++;
        if (o.en_cnt != TMO || o.err !== 1'b0 || !o.done) begin
            failures++;
            $display("FAIL timeout_ready_wins: got cycles=%0d err=%0b want %0d err=0",
                     o.en_cnt, o.err, TMO);
        end
        @(negedge iCLK);
        iRD_ADDR = 8'h31;
        iRD_REQ = 1;
        serve(9, 1'b0, 32'hFFFF_FFFF, o);
        m_last_wr = 0;
        checks++;
        if (o.en_cnt != TMO || o.err !== 1'b1 || o.rdat !== 32'h0) begin
            failures++;
            $display("FAIL timeout_read: got cycles=%0d err=%0b rdat=%h want %0d 1 0",
                     o.en_cnt, o.err, o.rdat, TMO);
        end
    endtask

    task automatic test_random();
        obs_t o;
        int c, kind, idx, n_tx;
        int s[2];
        logic pe[2];
        logic [31:0] pd[2];
        bit first_wr, w;
        logic [77:0] ev, got;
        for (int n = 0; n < 40; n++) begin
            @(negedge iCLK);
            kind = $urandom_range(0, 2);
            iRD_ADDR = 8'($urandom);
            iWR_ADDR = 8'($urandom);
            iWR_DATA = $urandom;
            iWR_STRB = 4'($urandom_range(0, 15));
            for (int j = 0; j < 2; j++) begin
                s[j] = $urandom_range(0, 6);
                pe[j] = 1'($urandom);
                pd[j] = $urandom;
            end
            iRD_REQ = (kind != 1);
            iWR_REQ = (kind != 0);
            c = cyc;
            first_wr = (kind == 2) ? !m_last_wr : (kind == 1);
            n_tx = (kind == 2) ? 2 : 1;
            for (int t = 0; t < n_tx; t++) begin
                w = (t == 0) ? first_wr : !first_wr;
                idx = w ? 1 : 0;
                ev = exp_vec(w, s[idx], pe[idx], pd[idx]);
                serve(s[idx], pe[idx], pd[idx], o);
                got = {o.wr, o.adr, o.wdat, o.strb, o.rdat, o.err};
                checks++;
                if (got !== ev) begin
                    failures++;
                    $display("FAIL rand_%0d_%0d_txn: got %h want %h", n, t, got, ev);
                end
                checks++;
                if (o.en_at != c + 1 || o.en_cnt != exp_en(s[idx]) ||
                    o.ack_at != o.en_at + o.en_cnt) begin
                    failures++;
                    $display("FAIL rand_%0d_%0d_timing: got en_at=%0d cnt=%0d ack=%0d want en_at=%0d cnt=%0d",
                             n, t, o.en_at, o.en_cnt, o.ack_at, c + 1, exp_en(s[idx]));
                end
                checks++;
                if (!o.done || !o.clean) begin
                    failures++;
                    $display("FAIL rand_%0d_%0d_protocol: got done=%0b clean=%0b want 1 1",
                             n, t, o.done, o.clean);
                end
                m_last_wr = w;
                c = o.ack_at + 1;
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit seen, acked;
        @(negedge iCLK);
        iRD_ADDR = 8'h20;
        iRD_REQ = 1;
        iPREADY = 0;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge iCLK);
            seen = oPREN;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rstmid_access: got no read enable want read enable");
        end
        iRST = 1;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: got %h want 0", all_out);
        end
        iWR_ADDR = 8'h50; iWR_DATA = 32'h600D_600D; iWR_STRB = 4'hC;
        iWR_REQ = 1;
        acked = 0;
        repeat (3) begin
            @(negedge iCLK);
            if (oRD_ACK || oWR_ACK || oBUSY) acked = 1;
        end
        checks++;
        if (acked) begin
            failures++;
            $display("FAIL rstmid_no_ack: got activity during reset want none");
        end
        iRST = 0;
        m_last_wr = 0;
        serve(0, 1'b0, 32'h0, o);
        checks++;
        if (o.wr !== 1'b1 || o.adr !== 8'h50 || !o.done) begin
            failures++;
            $display("FAIL rstmid_first: got wr=%0b adr=%h want write 50", o.wr, o.adr);
        end
        serve(0, 1'b0, 32'h0000_BEEF, o);
        checks++;
        if (o.wr !== 1'b0 || o.adr !== 8'h20 || o.rdat !== 32'h0000_BEEF) begin
            failures++;
            $display("FAIL rstmid_second: got wr=%0b adr=%h rdat=%h want read 20 0000beef",
                     o.wr, o.adr, o.rdat);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_wait_err();
        test_zero_strb();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
